// File: rtl/wishbone_arbiter_pkg.sv
// Shared types, default widths and the round-robin pick for the two-master
// Wishbone arbiter (master 0 = instruction cache, master 1 = data cache).
package wishbone_arbiter_pkg;

   localparam int ADDR_WIDTH = 28;
   localparam int DATA_WIDTH = 128;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

   typedef logic master_idx_t;

   // A lone requester wins; on a tie the master that was not granted last wins.
   function automatic master_idx_t rr_pick(input logic req0, input logic req1,
                                           input master_idx_t last);
      if (req0 && req1) begin
         return ~last;
      end else if (req1) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter: one owner per transaction, responses routed only
// to the owner, and a forced RTY frees the bus when the slave hangs.
module wishbone_arbiter
   import wishbone_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = wishbone_arbiter_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = wishbone_arbiter_pkg::DATA_WIDTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    m0_CYC,
   input  logic                    m0_STB,
   input  logic                    m0_WE,
   input  logic [ADDR_WIDTH-1:0]   m0_ADR,
   input  logic [DATA_WIDTH-1:0]   m0_DAT_M,
   input  logic [DATA_WIDTH/8-1:0] m0_SEL,
   output logic [DATA_WIDTH-1:0]   m0_DAT_S,
   output logic                    m0_ACK,
   output logic                    m0_RTY,
   input  logic                    m1_CYC,
   input  logic                    m1_STB,
   input  logic                    m1_WE,
   input  logic [ADDR_WIDTH-1:0]   m1_ADR,
   input  logic [DATA_WIDTH-1:0]   m1_DAT_M,
   input  logic [DATA_WIDTH/8-1:0] m1_SEL,
   output logic [DATA_WIDTH-1:0]   m1_DAT_S,
   output logic                    m1_ACK,
   output logic                    m1_RTY,
   output logic                    s_CYC,
   output logic                    s_STB,
   output logic                    s_WE,
   output logic [ADDR_WIDTH-1:0]   s_ADR,
   output logic [DATA_WIDTH-1:0]   s_DAT_M,
   output logic [DATA_WIDTH/8-1:0] s_SEL,
   input  logic [DATA_WIDTH-1:0]   s_DAT_S,
   input  logic                    s_ACK,
   input  logic                    s_RTY,
   output logic [1:0]              grant
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

   arb_state_t      state, next_state;
   master_idx_t     owner, next_owner;
   master_idx_t     last, next_last;
   logic [TW-1:0]   tcnt, next_tcnt;

   logic req0, req1, owner_cyc, tmo_fire, slave_rty;

   assign req0      = m0_CYC & m0_STB;
   assign req1      = m1_CYC & m1_STB;
   assign owner_cyc = owner ? m1_CYC : m0_CYC;
   assign tmo_fire  = (TIMEOUT != 0) && (state == BUSY) && (tcnt == TLIM) && !s_ACK && !s_RTY;
   // ACK wins over a simultaneous RTY from the slave.
   assign slave_rty = (s_RTY & ~s_ACK) | tmo_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         tcnt  <= '0;
      end else begin
         state <= next_state;
         owner <= next_owner;
         last  <= next_last;
         tcnt  <= next_tcnt;
      end
   end

   always_comb begin
      next_state = state;
      next_owner = owner;
      next_last  = last;
      next_tcnt  = tcnt;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               next_state = BUSY;
               next_owner = rr_pick(req0, req1, last);
               next_last  = rr_pick(req0, req1, last);
               next_tcnt  = '0;
            end
         end
         BUSY: begin
            if (s_ACK || s_RTY || tmo_fire || !owner_cyc) begin
               next_state = IDLE;
            end
            // Saturating so a disabled timeout never wraps back into range.
            if (!s_ACK && !s_RTY && (tcnt != '1)) begin
               next_tcnt = tcnt + TW'(1);
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      s_CYC    = 1'b0;
      s_STB    = 1'b0;
      s_WE     = 1'b0;
      s_ADR    = '0;
      s_DAT_M  = '0;
      s_SEL    = '0;
      m0_DAT_S = '0;
      m0_ACK   = 1'b0;
      m0_RTY   = 1'b0;
      m1_DAT_S = '0;
      m1_ACK   = 1'b0;
      m1_RTY   = 1'b0;
      grant    = 2'b00;
      if (state == BUSY) begin
         if (owner == 1'b0) begin
            grant    = 2'b01;
            s_CYC    = m0_CYC;
            s_STB    = m0_STB;
            s_WE     = m0_WE;
            s_ADR    = m0_ADR;
            s_DAT_M  = m0_DAT_M;
            s_SEL    = m0_SEL;
            m0_DAT_S = s_DAT_S;
            m0_ACK   = s_ACK;
            m0_RTY   = slave_rty;
         end else begin
            grant    = 2'b10;
            s_CYC    = m1_CYC;
            s_STB    = m1_STB;
            s_WE     = m1_WE;
            s_ADR    = m1_ADR;
            s_DAT_M  = m1_DAT_M;
            s_SEL    = m1_SEL;
            m1_DAT_S = s_DAT_S;
            m1_ACK   = s_ACK;
            m1_RTY   = slave_rty;
         end
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: expected master responses are queued
// when the slave response is driven and popped when the owner sees it.
module tb_wishbone_arbiter;

   localparam int AW  = 28;
   localparam int DW  = 128;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic          m0_CYC, m0_STB, m0_WE, m1_CYC, m1_STB, m1_WE;
   logic [AW-1:0] m0_ADR, m1_ADR, s_ADR;
   logic [DW-1:0] m0_DAT_M, m1_DAT_M, m0_DAT_S, m1_DAT_S, s_DAT_M, s_DAT_S;
   logic [SW-1:0] m0_SEL, m1_SEL, s_SEL;
   logic          m0_ACK, m0_RTY, m1_ACK, m1_RTY;
   logic          s_CYC, s_STB, s_WE, s_ACK, s_RTY;
   logic [1:0]    grant;

   typedef struct packed {
      logic          mst;
      logic          ack;
      logic          rty;
      logic [DW-1:0] dat;
   } resp_t;

   resp_t sb_q[$];
   resp_t exp_r;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wishbone_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_CYC(m0_CYC), .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADR(m0_ADR),
      .m0_DAT_M(m0_DAT_M), .m0_SEL(m0_SEL), .m0_DAT_S(m0_DAT_S),
      .m0_ACK(m0_ACK), .m0_RTY(m0_RTY),
      .m1_CYC(m1_CYC), .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADR(m1_ADR),
      .m1_DAT_M(m1_DAT_M), .m1_SEL(m1_SEL), .m1_DAT_S(m1_DAT_S),
      .m1_ACK(m1_ACK), .m1_RTY(m1_RTY),
      .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR),
      .s_DAT_M(s_DAT_M), .s_SEL(s_SEL), .s_DAT_S(s_DAT_S),
      .s_ACK(s_ACK), .s_RTY(s_RTY), .grant(grant)
   );

   function automatic resp_t sample(input logic mst);
      resp_t r;
      r.mst = mst;
      r.ack = mst ? m1_ACK : m0_ACK;
      r.rty = mst ? m1_RTY : m0_RTY;
      r.dat = mst ? m1_DAT_S : m0_DAT_S;
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_CYC = 1'b0; m0_STB = 1'b0; m0_WE = 1'b0;
      m1_CYC = 1'b0; m1_STB = 1'b0; m1_WE = 1'b0;
      s_ACK = 1'b0; s_RTY = 1'b0; s_DAT_S = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      m0_ADR = '1; m0_DAT_M = '1; m0_SEL = '1; m1_ADR = '0; m1_DAT_M = '0; m1_SEL = '0;
      m0_CYC = 1'b1; m0_STB = 1'b1; s_ACK = 1'b1; s_DAT_S = {16{8'h3C}};
      #12;
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", grant); end
      vectors++; if ({s_CYC, s_STB, s_WE, s_ADR, s_SEL} !== '0) begin miscompares++; $display("FAIL reset_s_bus: got cyc=%b stb=%b adr=%h sel=%h want all 0", s_CYC, s_STB, s_ADR, s_SEL); end
      vectors++; if (sample(1'b0) !== '0) begin miscompares++; $display("FAIL reset_m0_resp: got %h want 0", sample(1'b0)); end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_tie();
      cyc();
      m0_CYC = 1'b1; m0_STB = 1'b1; m0_WE = 1'b0; m0_ADR = 28'h0000100;
      m1_CYC = 1'b1; m1_STB = 1'b1; m1_WE = 1'b1; m1_ADR = 28'h0000200;
      m1_DAT_M = {4{32'hDEADBEEF}}; m1_SEL = 16'h00FF;
      cyc();
      vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL tie_first_grant: got %b want 01", grant); end
      vectors++; if (s_ADR !== 28'h0000100) begin miscompares++; $display("FAIL tie_first_adr: got %h want 0000100", s_ADR); end
      s_ACK = 1'b1; s_DAT_S = {4{32'h11223344}};
      sb_q.push_back('{mst: 1'b0, ack: 1'b1, rty: 1'b0, dat: {4{32'h11223344}}});
      #1;
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL tie_m0_resp: got %h want %h", sample(exp_r.mst), exp_r); end
      vectors++; if (sample(1'b1) !== {1'b1, 1'b0, 1'b0, {DW{1'b0}}}) begin miscompares++; $display("FAIL tie_m1_isolated: got ack=%b dat=%h want 0", m1_ACK, m1_DAT_S); end
      cyc();
      s_ACK = 1'b0; s_DAT_S = '0;
      #1;
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL tie_dead_cycle: got %b want 00", grant); end
      cyc();
      vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL tie_second_grant: got %b want 10", grant); end
      vectors++; if ({s_WE, s_SEL, s_ADR, s_DAT_M} !== {1'b1, 16'h00FF, 28'h0000200, {4{32'hDEADBEEF}}}) begin
         miscompares++; $display("FAIL tie_m1_forward: got we=%b sel=%h adr=%h dat=%h want we=1 sel=00ff adr=0000200 dat=deadbeef*4", s_WE, s_SEL, s_ADR, s_DAT_M);
      end
      s_ACK = 1'b1; s_DAT_S = {4{32'h55667788}};
      sb_q.push_back('{mst: 1'b1, ack: 1'b1, rty: 1'b0, dat: {4{32'h55667788}}});
      #1;
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL tie_m1_resp: got %h want %h", sample(exp_r.mst), exp_r); end
      vectors++; if (m0_ACK !== 1'b0) begin miscompares++; $display("FAIL tie_m0_no_ack: got %b want 0", m0_ACK); end
      cyc();
      clear_inputs();
   endtask

   task automatic test_retry();
      cyc();
      m1_CYC = 1'b1; m1_STB = 1'b1; m1_WE = 1'b0; m1_ADR = 28'h0000300;
      cyc();
      vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL retry_grant: got %b want 10", grant); end
      cyc();
      s_RTY = 1'b1; m0_CYC = 1'b1; m0_STB = 1'b1; m0_ADR = 28'h0000400;
      sb_q.push_back('{mst: 1'b1, ack: 1'b0, rty: 1'b1, dat: '0});
      #1;
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL retry_m1_resp: got %h want %h", sample(exp_r.mst), exp_r); end
      vectors++; if (m0_RTY !== 1'b0) begin miscompares++; $display("FAIL retry_m0_no_rty: got %b want 0", m0_RTY); end
      cyc();
      vectors++; if ({grant, m1_RTY} !== 3'b000) begin miscompares++; $display("FAIL retry_one_cycle: got grant=%b rty=%b want 00 0", grant, m1_RTY); end
      s_RTY = 1'b0;
      cyc();
      vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL retry_tie_m0: got %b want 01", grant); end
      s_ACK = 1'b1; s_DAT_S = {8{16'hBEEF}};
      sb_q.push_back('{mst: 1'b0, ack: 1'b1, rty: 1'b0, dat: {8{16'hBEEF}}});
      #1;
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL retry_m0_resp: got %h want %h", sample(exp_r.mst), exp_r); end
      cyc();
      clear_inputs();
   endtask

   task automatic test_single_read();
      cyc();
      m0_CYC = 1'b1; m0_STB = 1'b1; m0_WE = 1'b0; m0_ADR = 28'h0000010; m0_SEL = '1;
      for (int c = 1; c <= 3; c++) begin
         cyc();
         if (c == 3) begin
            s_ACK = 1'b1; s_DAT_S = {16{8'hA5}};
            sb_q.push_back('{mst: 1'b0, ack: 1'b1, rty: 1'b0, dat: {16{8'hA5}}});
         end
         #1;
         vectors++; if ({grant, s_CYC, s_STB, s_ADR} !== {2'b01, 1'b1, 1'b1, 28'h0000010}) begin
            miscompares++; $display("FAIL single_busy_c%0d: got grant=%b cyc=%b stb=%b adr=%h want 01 1 1 0000010", c, grant, s_CYC, s_STB, s_ADR);
         end
         vectors++; if ({m1_ACK, m0_ACK} !== {1'b0, (c == 3)}) begin
            miscompares++; $display("FAIL single_ack_c%0d: got m1=%b m0=%b want m1=0 m0=%b", c, m1_ACK, m0_ACK, (c == 3));
         end
      end
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL single_resp: got %h want %h", sample(exp_r.mst), exp_r); end
      cyc();
      vectors++; if ({grant, s_CYC, m0_ACK, m0_DAT_S} !== '0) begin
         miscompares++; $display("FAIL single_idle_drop: got grant=%b cyc=%b ack=%b dat=%h want all 0", grant, s_CYC, m0_ACK, m0_DAT_S);
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      cyc();
      m0_CYC = 1'b1; m0_STB = 1'b1; m0_ADR = 28'h0000020;
      cyc();
      s_ACK = 1'b1; s_DAT_S = {2{64'h0123456789ABCDEF}};
      sb_q.push_back('{mst: 1'b0, ack: 1'b1, rty: 1'b0, dat: {2{64'h0123456789ABCDEF}}});
      #1;
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL b2b_first_resp: got %h want %h", sample(exp_r.mst), exp_r); end
      cyc();
      s_ACK = 1'b0; s_DAT_S = '0;
      #1;
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL b2b_dead_cycle: got %b want 00", grant); end
      cyc();
      vectors++; if ({grant, s_CYC} !== 3'b011) begin miscompares++; $display("FAIL b2b_regrant: got grant=%b cyc=%b want 01 1", grant, s_CYC); end
      s_ACK = 1'b1;
      cyc();
      clear_inputs();
   endtask

   task automatic test_timeout();
      int seen;
      seen = 0;
      cyc();
      m1_CYC = 1'b1; m1_STB = 1'b1; m1_ADR = 28'h0000500;
      sb_q.push_back('{mst: 1'b1, ack: 1'b0, rty: 1'b1, dat: '0});
      for (int c = 1; c <= 10 && seen == 0; c++) begin
         cyc();
         if (m1_ACK || m1_RTY) seen = c;
      end
      vectors++; if (seen != TMO + 1) begin miscompares++; $display("FAIL timeout_cycle: got busy cycle %0d want %0d", seen, TMO + 1); end
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL timeout_resp: got %h want %h", sample(exp_r.mst), exp_r); end
      cyc();
      vectors++; if ({grant, m1_RTY} !== 3'b000) begin miscompares++; $display("FAIL timeout_release: got grant=%b rty=%b want 00 0", grant, m1_RTY); end
      clear_inputs();
   endtask

   task automatic test_abort();
      cyc();
      m0_CYC = 1'b1; m0_STB = 1'b1; m0_ADR = 28'h0000600;
      cyc();
      vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL abort_grant: got %b want 01", grant); end
      cyc();
      m0_CYC = 1'b0; m0_STB = 1'b0;
      #1;
      vectors++; if ({grant, s_CYC} !== 3'b010) begin miscompares++; $display("FAIL abort_same_cycle: got grant=%b cyc=%b want 01 0", grant, s_CYC); end
      cyc();
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL abort_idle: got %b want 00", grant); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_busy();
      cyc();
      m1_CYC = 1'b1; m1_STB = 1'b1; m1_ADR = 28'h0000700;
      cyc();
      #3;
      rst_n = 1'b0; s_ACK = 1'b1; s_DAT_S = {16{8'h77}};
      #1;
      vectors++; if ({grant, s_CYC, s_STB, s_ADR} !== '0) begin miscompares++; $display("FAIL rst_async_bus: got grant=%b cyc=%b adr=%h want all 0", grant, s_CYC, s_ADR); end
      vectors++; if ({m1_ACK, m1_DAT_S} !== '0) begin miscompares++; $display("FAIL rst_async_resp: got ack=%b dat=%h want 0", m1_ACK, m1_DAT_S); end
      @(negedge clk);
      s_ACK = 1'b0; s_DAT_S = '0; m0_CYC = 1'b1; m0_STB = 1'b1; m0_ADR = 28'h0000800;
      rst_n = 1'b1;
      cyc();
      vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rst_restart_m0: got %b want 01", grant); end
   endtask

   task automatic test_simultaneous();
      s_ACK = 1'b1; s_RTY = 1'b1; s_DAT_S = {4{32'hCAFEF00D}};
      sb_q.push_back('{mst: 1'b0, ack: 1'b1, rty: 1'b0, dat: {4{32'hCAFEF00D}}});
      #1;
      exp_r = sb_q.pop_front();
      vectors++; if (sample(exp_r.mst) !== exp_r) begin miscompares++; $display("FAIL simul_ack_wins: got %h want %h", sample(exp_r.mst), exp_r); end
      cyc();
      clear_inputs();
      #1;
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL simul_release: got %b want 00", grant); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_tie();
      test_retry();
      test_single_read();
      test_back_to_back();
      test_timeout();
      test_abort();
      test_reset_mid_busy();
      test_simultaneous();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
